// File: rtl/mux_dmux_sched_if.sv
// Handshake bundle between the requesters and the round-robin channel scheduler.
// The scheduler side drives grants and the MUX/DMUX controls; requesters drive req/dest.
interface mux_dmux_sched_if;
   logic [3:0] req;
   logic [7:0] dest;
   logic [3:0] grant;
   logic [1:0] mux_select;
   logic [1:0] dmux_select;
   logic       dmux_enable;
   logic       busy;
   logic       slot_done;

   modport master (
      output req, dest,
      input  grant, mux_select, dmux_select, dmux_enable, busy, slot_done
   );

   modport slave (
      input  req, dest,
      output grant, mux_select, dmux_select, dmux_enable, busy, slot_done
   );
endinterface

// File: rtl/mux_dmux_sched.sv
// Round-robin scheduler granting the shared 4:1 MUX / 1:4 DMUX channel to one of four
// requesters per bounded slot; all outputs are registered.
module mux_dmux_sched #(
   parameter int SLOT_LEN = 4
) (
   input logic            clk,
   input logic            rst,
   mux_dmux_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, RELEASE} state_t;

   localparam logic [7:0] SLOT_MAX = 8'(SLOT_LEN);

   state_t     state_q, state_n;
   logic [1:0] last_q, last_n;
   logic [7:0] cnt_q, cnt_n;
   logic [3:0] grant_q, grant_n;
   logic [1:0] mux_q, mux_n;
   logic [1:0] dsel_q, dsel_n;
   logic       en_q, en_n;
   logic       busy_q, busy_n;
   logic       done_q, done_n;

   logic       pick_vld;
   logic [1:0] pick_idx;

   // First requester at or after last+1, wrapping; last itself is checked last.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign {pick_vld, pick_idx} = rr_pick(bus.req, last_q);

   always_comb begin
      state_n = state_q;
      last_n  = last_q;
      cnt_n   = cnt_q;
      grant_n = grant_q;
      mux_n   = mux_q;
      dsel_n  = dsel_q;
      en_n    = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state_q)
         IDLE, RELEASE: begin
            if (pick_vld) begin
               // Selects and destination are latched here and frozen for the slot.
               state_n = SETUP;
               grant_n = 4'b0001 << pick_idx;
               mux_n   = pick_idx;
               dsel_n  = bus.dest[{pick_idx, 1'b0} +: 2];
               last_n  = pick_idx;
               busy_n  = 1'b1;
            end else begin
               state_n = IDLE;
               grant_n = 4'b0000;
            end
         end
         SETUP: begin
            state_n = XFER;
            cnt_n   = 8'd1;
            en_n    = 1'b1;
            busy_n  = 1'b1;
         end
         XFER: begin
            busy_n = 1'b1;
            if (cnt_q == SLOT_MAX || !bus.req[mux_q]) begin
               state_n = RELEASE;
               grant_n = 4'b0000;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt_q + 8'd1;
               en_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         cnt_q   <= 8'd0;
         grant_q <= 4'b0000;
         mux_q   <= 2'd0;
         dsel_q  <= 2'd0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         last_q  <= last_n;
         cnt_q   <= cnt_n;
         grant_q <= grant_n;
         mux_q   <= mux_n;
         dsel_q  <= dsel_n;
         en_q    <= en_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.mux_select  = mux_q;
   assign bus.dmux_select = dsel_q;
   assign bus.dmux_enable = en_q;
   assign bus.busy        = busy_q;
   assign bus.slot_done   = done_q;

endmodule

// File: tb/tb_mux_dmux_sched.sv
// Directed bench for mux_dmux_sched: stimulus queues the slot each grant should produce,
// a negedge monitor reconstructs every completed slot and compares it against the queue.
module tb_mux_dmux_sched;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mux_dmux_sched_if bus();

   mux_dmux_sched #(.SLOT_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {grant, mux_select, dmux_select, enable cycles, slot cycles SETUP..RELEASE}
   logic [23:0] exp_q[$];

   function automatic logic [23:0] mk(input logic [3:0] g, input logic [1:0] m,
                                      input logic [1:0] d, input logic [7:0] en,
                                      input logic [7:0] len);
      return {g, m, d, en, len};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic       in_slot = 1'b0;
   logic [3:0] cur_grant;
   logic [1:0] cur_mux;
   logic [1:0] cur_dsel;
   logic [7:0] en_cnt;
   logic [7:0] len_cnt;

   always @(negedge clk) begin
      if (rst) begin
         in_slot = 1'b0;
      end else if (!in_slot && bus.grant != 4'b0000) begin
         in_slot   = 1'b1;
         cur_grant = bus.grant;
         cur_mux   = bus.mux_select;
         cur_dsel  = bus.dmux_select;
         en_cnt    = 8'd0;
         len_cnt   = 8'd1;
         chk("setup_enable_low", 32'(bus.dmux_enable), 32'd0);
      end else if (in_slot) begin
         len_cnt = len_cnt + 8'd1;
         if (bus.dmux_enable) begin
            en_cnt = en_cnt + 8'd1;
            chk("dsel_stable_xfer", 32'(bus.dmux_select), 32'(cur_dsel));
         end
         if (bus.slot_done) begin
            in_slot = 1'b0;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_slot: got %0h expected none",
                        {cur_grant, cur_mux, cur_dsel, en_cnt, len_cnt});
            end else begin
               chk("slot", 32'({cur_grant, cur_mux, cur_dsel, en_cnt, len_cnt}),
                   32'(exp_q.pop_front()));
            end
         end
      end else if (bus.slot_done) begin
         total++;
         bad++;
         $display("FAIL stray_slot_done: got 1 expected 0");
      end
   end

   initial begin
      rst      = 1'b1;
      bus.req  = 4'hF;
      bus.dest = 8'h00;
      repeat (3) tick();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_mux", 32'(bus.mux_select), 32'd0);
      chk("rst_dsel", 32'(bus.dmux_select), 32'd0);
      chk("rst_enable", 32'(bus.dmux_enable), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.slot_done), 32'd0);

      // Full contention: dest d3..d0 = 0,1,2,3
      bus.dest = 8'b00_01_10_11;
      exp_q.push_back(mk(4'b0001, 2'd0, 2'd3, 8'd4, 8'd6));
      exp_q.push_back(mk(4'b0010, 2'd1, 2'd2, 8'd4, 8'd6));
      exp_q.push_back(mk(4'b0100, 2'd2, 2'd1, 8'd4, 8'd6));
      exp_q.push_back(mk(4'b1000, 2'd3, 2'd0, 8'd4, 8'd6));
      exp_q.push_back(mk(4'b0001, 2'd0, 2'd3, 8'd1, 8'd3));
      rst = 1'b0;
      tick();
      chk("first_grant", 32'(bus.grant), 32'h1);
      chk("first_busy", 32'(bus.busy), 32'd1);
      repeat (24) tick();
      chk("wrap_grant", 32'(bus.grant), 32'h1);
      bus.req = 4'b0000;
      repeat (4) tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_mux_hold", 32'(bus.mux_select), 32'd0);
      chk("idle_dsel_hold", 32'(bus.dmux_select), 32'd3);

      // Single requester 2 to destination 1
      bus.dest = 8'b00_01_00_00;
      bus.req  = 4'b0100;
      exp_q.push_back(mk(4'b0100, 2'd2, 2'd1, 8'd4, 8'd6));
      repeat (6) tick();
      chk("single_done", 32'(bus.slot_done), 32'd1);
      bus.req = 4'b0000;
      repeat (2) tick();
      chk("single_idle", 32'(bus.busy), 32'd0);
      chk("single_mux_hold", 32'(bus.mux_select), 32'd2);
      chk("single_dsel_hold", 32'(bus.dmux_select), 32'd1);

      // Early release of requester 1, then requester 3 with a mid-slot dest change
      bus.dest = 8'b01_00_10_00;
      bus.req  = 4'b0010;
      exp_q.push_back(mk(4'b0010, 2'd1, 2'd2, 8'd2, 8'd4));
      exp_q.push_back(mk(4'b1000, 2'd3, 2'd1, 8'd4, 8'd6));
      tick();
      chk("early_grant", 32'(bus.grant), 32'h2);
      bus.req = 4'b1010;
      repeat (2) tick();
      bus.req = 4'b1000;
      tick();
      chk("early_release_en", 32'(bus.dmux_enable), 32'd0);
      chk("early_release_done", 32'(bus.slot_done), 32'd1);
      chk("early_release_grant", 32'(bus.grant), 32'd0);
      tick();
      chk("next_grant", 32'(bus.grant), 32'h8);
      repeat (2) tick();
      bus.dest = 8'b10_11_11_11;
      tick();
      chk("capture_dsel", 32'(bus.dmux_select), 32'd1);
      chk("capture_en", 32'(bus.dmux_enable), 32'd1);
      repeat (2) tick();
      bus.req = 4'b0000;
      repeat (2) tick();
      chk("capture_dsel_hold", 32'(bus.dmux_select), 32'd1);

      // Reset in the middle of requester 2's XFER window
      bus.dest = 8'b00_00_00_01;
      bus.req  = 4'b0100;
      tick();
      chk("pre_rst_grant", 32'(bus.grant), 32'h4);
      repeat (2) tick();
      chk("pre_rst_en", 32'(bus.dmux_enable), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_en", 32'(bus.dmux_enable), 32'd0);
      chk("midrst_grant", 32'(bus.grant), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_mux", 32'(bus.mux_select), 32'd0);
      bus.req = 4'b1001;
      repeat (2) tick();
      exp_q.push_back(mk(4'b0001, 2'd0, 2'd1, 8'd4, 8'd6));
      rst = 1'b0;
      tick();
      chk("post_rst_grant", 32'(bus.grant), 32'h1);
      bus.req = 4'b0001;
      repeat (5) tick();
      bus.req = 4'b0000;
      repeat (3) tick();

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
